ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end: PC generation, pipelined valid/ready requests to
//  instruction memory with wait-states, a DEPTH-entry prefetch queue feeding the IF/ID register,
//  and clean redirect (branch/flush) handling that discards stale in-flight responses.
//  Sits between imem and IFID; replaces the bare pc + pc_adder + next-PC mux of the IF stage.
// PARAMETERS
//  XLEN      32  PC / address width
//  DEPTH     4   prefetch queue entries; power of two, >= 2; also max in-flight requests
//  PC_STEP   1   PC increment per instruction (1 = word-addressed imem, 4 = byte-addressed)
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     asynchronous reset, active-low
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     imem accepts request this cycle
//  imem_req_addr   out  XLEN  fetch address
//  imem_rsp_valid  in   1     response valid; responses return in request order, >= 1 cycle later
//  imem_rsp_data   in   32    instruction word
//  redirect_valid  in   1     branch taken / flush from MEM stage
//  redirect_pc     in   XLEN  redirect target
//  stall           in   1     ID hazard stall: hold current output
//  out_valid       out  1     ir_out/pc_out hold a valid instruction
//  ir_out          out  32    instruction at queue head (NOP when !out_valid)
//  pc_out          out  XLEN  PC of ir_out (0 when !out_valid)
// BEHAVIOUR
//  Reset (rst=0, async): fetch_pc=RESET_PC, queue empty, in-flight=0, discard=0, state RUN;
//   imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, ir_out=NOP (32'h0000_0013), pc_out=0.
//   First request asserted in the first cycle after rst deasserts.
//  Issue: imem_req_valid = (occupancy + in_flight < DEPTH) & !redirect_valid.
//   Handshake on valid&ready: in_flight+1, fetch_pc += PC_STEP (wraps mod 2^XLEN).
//   addr/valid stay stable while valid & !ready (no retraction).
//  Response: if discard>0, drop data, discard-1, in_flight-1; else push {fetch tag PC, data}, in_flight-1.
//   Tag PC comes from an internal DEPTH-entry PC FIFO filled at issue (no address reuse from imem).
//  Output: head entry drives ir_out/pc_out combinationally; out_valid = !empty.
//   Pop when out_valid & !stall. Push and pop same cycle: occupancy unchanged. Full queue never
//   overflows (issue gating guarantees a slot for every in-flight response).
//  Redirect (highest priority): same cycle queue and PC FIFO cleared, out_valid=0 next cycle,
//   discard <= in_flight minus any response arriving that cycle (that response also dropped),
//   fetch_pc <= redirect_pc, no request issued that cycle; first request to redirect_pc next cycle.
//   A request handshaking in the redirect cycle cannot occur (valid forced low).
//   Redirect with stall: redirect wins, head discarded.
//  FSM: RUN (discard==0) <-> DRAIN (discard>0). DRAIN still issues new requests (ordering
//   guarantees stale responses arrive first); DRAIN->RUN when last stale response consumed.
//   Redirect in DRAIN adds to discard (re-computed from in_flight as above).
//  Counters: occupancy, in_flight, discard are clog2(DEPTH)+1 bits; never exceed DEPTH (assert).
//  Latency: redirect to out_valid = 2 cycles + imem latency; zero-wait steady state 1 instr/cycle.
// STRUCTURE
//  Package ifq_pkg: NOP_INSTR constant, ifq_state_e {RUN, DRAIN}, queue entry struct {pc, ir}.
//  Sub-module ifq_fifo (param WIDTH, DEPTH; push/pop/clear, full/empty, count) instantiated twice:
//   instruction queue and issued-PC tag FIFO. Top of block: counters, FSM, issue logic.
// TESTING
//  1 Reset then imem ready=1, 1-cycle latency, stall=0 -> addrs 0,1,2,3...; out pc 0,1,2 one/cycle.
//  2 stall=1 for 6 cycles -> queue fills to DEPTH=4, req_valid drops, ir_out/pc_out held constant.
//  3 imem_req_ready low 3 cycles with valid=1 -> req_addr stable, no duplicate or skipped PC.
//  4 3 requests in flight, redirect_pc=0x40 -> 3 responses dropped, next out pc 0x40, 0x41.
//  5 Redirect in same cycle as response and as stall -> response dropped, out_valid=0 next cycle.
//  6 rst asserted mid-DRAIN -> all outputs to reset values immediately; restart fetch at RESET_PC.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction-fetch queue: the NOP bubble,
// the drain/run state encoding and the default-width queue entry layout.
package ifq_pkg;

    // addi x0, x0, 0 -- what ID sees whenever no real instruction is ready
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // RUN: every response is kept; DRAIN: stale responses from before a redirect are still due
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ifq_state_e;

    // Queue entry for the default 32-bit PC; the top packs {pc, ir} in this same order
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Small synchronous FIFO with a single-cycle clear; used for both the
// instruction queue and the issued-PC tag FIFO. Read data is combinational from the head.
module ifq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array needs no reset; only slots between the pointers are ever read as valid
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == DEPTH[AW:0]);
    assign empty = (count == '0);

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop && !clear));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && empty && !clear));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: generates PCs, issues pipelined requests to imem,
// buffers responses in a prefetch queue for IF/ID and throws away responses that
// were already in flight when a branch or flush redirected the fetch stream.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            out_valid,
    output logic [31:0]     ir_out,
    output logic [XLEN-1:0] pc_out
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_DEPTH = DEPTH[CW-1:0];

    logic [XLEN-1:0] fetch_pc, fetch_pc_next;
    logic [CW-1:0]   in_flight, in_flight_next;
    logic [CW-1:0]   discard, discard_next;
    ifq_state_e      state, state_next;

    logic [CW-1:0]      occupancy;
    logic [CW:0]        pending_sum;
    logic               fire;
    logic               rsp_accept;
    logic               iq_pop;
    logic               iq_empty, iq_full;
    logic [XLEN+31:0]   iq_dout;
    logic [XLEN-1:0]    tag_dout;
    logic               tag_empty, tag_full;
    logic [CW-1:0]      tag_count;

    // Every in-flight request owns a future queue slot, so the sum bounds issue; rst gates the async-reset window
    assign pending_sum    = {1'b0, occupancy} + {1'b0, in_flight};
    assign imem_req_valid = rst && (pending_sum < {1'b0, CNT_DEPTH}) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign fire           = imem_req_valid && imem_req_ready;

    assign rsp_accept = imem_rsp_valid && !redirect_valid && (discard == '0);
    assign iq_pop     = !iq_empty && !stall && !redirect_valid;

    assign out_valid = !iq_empty;
    assign ir_out    = out_valid ? iq_dout[31:0] : NOP_INSTR;
    assign pc_out    = out_valid ? iq_dout[XLEN+31:32] : '0;

    ifq_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fire),
        .pop   (rsp_accept),
        .clear (redirect_valid),
        .din   (fetch_pc),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    ifq_fifo #(.WIDTH(XLEN + 32), .DEPTH(DEPTH)) u_instr_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_accept),
        .pop   (iq_pop),
        .clear (redirect_valid),
        .din   ({tag_dout, imem_rsp_data}),
        .dout  (iq_dout),
        .full  (iq_full),
        .empty (iq_empty),
        .count (occupancy)
    );

    // Next-state for PC, outstanding-request and stale-response counters; a redirect turns all in-flight work stale
    always_comb begin
        fetch_pc_next  = fetch_pc;
        in_flight_next = in_flight;
        discard_next   = discard;
        if (fire)           in_flight_next = in_flight_next + CNT_ONE;
        if (imem_rsp_valid) in_flight_next = in_flight_next - CNT_ONE;
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            discard_next  = imem_rsp_valid ? (in_flight - CNT_ONE) : in_flight;
        end else begin
            if (fire) fetch_pc_next = fetch_pc + PC_STEP;
            if (imem_rsp_valid && (discard != '0)) discard_next = discard - CNT_ONE;
        end
        state_next = (discard_next != '0) ? DRAIN : RUN;
    end

    // Register the fetch-side bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            in_flight <= '0;
            discard   <= '0;
            state     <= RUN;
        end else begin
            fetch_pc  <= fetch_pc_next;
            in_flight <= in_flight_next;
            discard   <= discard_next;
            state     <= state_next;
        end
    end

    a_inflight_max: assert property (@(posedge clk) disable iff (!rst) in_flight <= CNT_DEPTH);
    a_discard_max:  assert property (@(posedge clk) disable iff (!rst) discard <= in_flight);
    a_occ_max:      assert property (@(posedge clk) disable iff (!rst) occupancy <= CNT_DEPTH);
    a_state_match:  assert property (@(posedge clk) disable iff (!rst) (state == DRAIN) == (discard != '0));
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst) !(imem_rsp_valid && in_flight == '0));
    a_iq_room:      assert property (@(posedge clk) disable iff (!rst) !(rsp_accept && iq_full && !iq_pop));
    a_tag_room:     assert property (@(posedge clk) disable iff (!rst) !(fire && tag_full && !rsp_accept));
    a_tag_present:  assert property (@(posedge clk) disable iff (!rst) !(rsp_accept && tag_empty));
    a_tag_count:    assert property (@(posedge clk) disable iff (!rst) tag_count <= in_flight);

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized self-checking bench for ifetch_queue: an in-order imem model with
// random latency, and a reference model that tracks the fetch stream as plain
// queues of addresses (pending requests, buffered instructions).
module tb_ifetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic [31:0] ir_out;
    logic [31:0] pc_out;

    int checks = 0;
    int failures = 0;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    bit          pend_stale[$];
    logic [31:0] q_pc[$];
    logic [31:0] exp_fetch = '0;
    int          cyc = 0;

    int          p_ready = 100;
    int          p_stall = 0;
    int          p_redirect = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          use_force_pc = 1'b0;
    logic [31:0] force_pc = '0;

    always #5 clk = ~clk;

    ifetch_queue #(.XLEN(32), .DEPTH(DEPTH), .PC_STEP(32'd1), .RESET_PC(32'd0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .ir_out         (ir_out),
        .pc_out         (pc_out)
    );

    // Instruction memory contents: a scrambled function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_req_valid"}, imem_req_valid, 1'b0);
        check_output({tag, "_req_addr"}, imem_req_addr, 32'd0);
        check_output({tag, "_out_valid"}, out_valid, 1'b0);
        check_output({tag, "_ir_out"}, ir_out, NOP);
        check_output({tag, "_pc_out"}, pc_out, 32'd0);
    endtask

    // Asynchronous reset applied mid-cycle; the model and imem forget everything outstanding
    task automatic do_reset(input string tag);
        rst = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        stall = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        pend_stale.delete();
        q_pc.delete();
        exp_fetch = '0;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs({tag, "_held"});
        rst = 1'b1;
    endtask

    // Drive one cycle of inputs, just after the rising edge
    task automatic apply_stimulus();
        imem_req_ready = ($urandom_range(99) < p_ready);
        stall          = ($urandom_range(99) < p_stall);
        redirect_valid = ($urandom_range(99) < p_redirect);
        if (use_force_pc)               redirect_pc = force_pc;
        else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFFD;
        else                            redirect_pc = $urandom;
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // Compare outputs against the model, then advance the model across the coming edge
    task automatic evaluate();
        bit          exp_v;
        bit          stale;
        logic [31:0] a;
        stale = 1'b0;
        a = '0;
        exp_v = ((q_pc.size() + pend_addr.size()) < DEPTH) && !redirect_valid;
        check_output("req_valid", imem_req_valid, exp_v);
        if (exp_v) check_output("req_addr", imem_req_addr, exp_fetch);
        check_output("out_valid", out_valid, q_pc.size() != 0);
        if (q_pc.size() != 0) begin
            check_output("pc_out", pc_out, q_pc[0]);
            check_output("ir_out", ir_out, mem_word(q_pc[0]));
        end else begin
            check_output("ir_nop", ir_out, NOP);
            check_output("pc_zero", pc_out, 32'd0);
        end
        if (imem_rsp_valid) begin
            a = pend_addr.pop_front();
            void'(pend_due.pop_front());
            stale = pend_stale.pop_front();
        end
        if (redirect_valid) begin
            foreach (pend_stale[i]) pend_stale[i] = 1'b1;
            q_pc.delete();
            exp_fetch = redirect_pc;
        end else begin
            if (q_pc.size() != 0 && !stall) void'(q_pc.pop_front());
            if (imem_rsp_valid && !stale) q_pc.push_back(a);
            if (exp_v && imem_req_ready) begin
                pend_addr.push_back(exp_fetch);
                pend_due.push_back(cyc + $urandom_range(lat_max, lat_min));
                pend_stale.push_back(1'b0);
                exp_fetch = exp_fetch + 32'd1;
            end
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus();
            #4;
            evaluate();
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic set_knobs(input int rdy, input int stl, input int rdr, input int lmin, input int lmax);
        p_ready = rdy;
        p_stall = stl;
        p_redirect = rdr;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    initial begin
        #1;
        do_reset("reset");

        // Zero-wait streaming, one instruction per cycle
        set_knobs(100, 0, 0, 1, 1);
        step(20);

        // Consumer stalls: queue fills, requests stop, head held
        set_knobs(100, 100, 0, 1, 1);
        step(6);

        // imem back-pressure while a request is pending
        set_knobs(0, 0, 0, 1, 1);
        step(6);
        set_knobs(100, 0, 0, 1, 1);
        step(4);

        // Redirect to 0x40 with three requests outstanding
        set_knobs(100, 0, 0, 3, 3);
        step(4);
        use_force_pc = 1'b1;
        force_pc = 32'h40;
        set_knobs(100, 0, 100, 3, 3);
        step(1);
        set_knobs(100, 0, 0, 1, 1);
        step(12);

        // Redirect coinciding with a response and a stall
        set_knobs(100, 0, 0, 1, 1);
        step(4);
        force_pc = 32'h80;
        set_knobs(100, 100, 100, 1, 1);
        step(1);
        set_knobs(100, 0, 0, 1, 1);
        step(8);

        // Reset while stale responses are still due
        set_knobs(100, 0, 0, 6, 6);
        step(4);
        force_pc = 32'h200;
        set_knobs(100, 0, 100, 6, 6);
        step(1);
        set_knobs(100, 0, 0, 6, 6);
        step(1);
        do_reset("mid_drain_reset");
        set_knobs(100, 0, 0, 1, 2);
        step(10);

        // Random mix, including redirects near the top of the address space
        use_force_pc = 1'b0;
        set_knobs(70, 25, 5, 1, 4);
        step(500);
        set_knobs(90, 10, 15, 1, 3);
        step(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
